// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, length encodings and FSM states for the RAM arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return (len == LEN_B || len == LEN_H) ? len : LEN_W;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side request/response signals and the byte-wide RAM port
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_jump_i;
  logic              inst_ready_o;
  logic [DATA_W-1:0] inst_o;
  logic              pc_plus4_ready_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [2:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_done_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  modport slave (
    input  if_req_i, if_addr_i, if_jump_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    output inst_ready_o, inst_o, pc_plus4_ready_o, mem_done_o, mem_rdata_o, ram_dout_o,
           ram_a_o, ram_wr_o
  );
  modport master (
    output if_req_i, if_addr_i, if_jump_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    input  inst_ready_o, inst_o, pc_plus4_ready_o, mem_done_o, mem_rdata_o, ram_dout_o,
           ram_a_o, ram_wr_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and load/store onto one byte-wide RAM port, little-endian assembly
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  mem_arbiter_if.slave bus
);
  state_t            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt, r_len, w_len, w_idx;
  logic [ADDR_W-1:0] r_addr, w_addr, r_a, w_a, w_step;
  logic [DATA_W-1:0] r_wdata, w_wdata, r_asm, w_asm, r_inst, w_inst, r_rdata, w_rdata, w_cap;
  logic [7:0]        r_dout, w_dout, w_wbyte;
  logic              r_wr, w_wr, r_inst_rdy, w_inst_rdy, r_done, w_done;
  assign w_idx   = r_cnt + 3'd1;
  assign w_step  = r_addr + ADDR_W'(w_idx);
  assign w_cap   = r_asm | (DATA_W'(bus.ram_din_i) << {r_cnt - 3'd1, 3'b000});
  assign w_wbyte = 8'(r_wdata >> {w_idx, 3'b000});
  assign bus.ram_a_o          = r_a;
  assign bus.ram_dout_o       = r_dout;
  assign bus.ram_wr_o         = r_wr & rdy;
  assign bus.inst_o           = r_inst;
  assign bus.inst_ready_o     = r_inst_rdy;
  assign bus.pc_plus4_ready_o = r_inst_rdy;
  assign bus.mem_rdata_o      = r_rdata;
  assign bus.mem_done_o       = r_done;
  // next state, next RAM port drive and result capture
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_len      = r_len;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_asm      = r_asm;
    w_a        = r_a;
    w_dout     = r_dout;
    w_wr       = r_wr;
    w_inst     = r_inst;
    w_rdata    = r_rdata;
    w_inst_rdy = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_req_i) begin
          w_state = bus.mem_we_i ? MEM_WR : MEM_RD;
          w_len   = norm_len(bus.mem_len_i);
          w_addr  = bus.mem_addr_i;
          w_a     = bus.mem_addr_i;
          w_wdata = bus.mem_wdata_i;
          w_dout  = bus.mem_wdata_i[7:0];
          w_wr    = bus.mem_we_i;
          w_cnt   = 3'd0;
          w_asm   = ZERO_WORD;
        end else if (bus.if_req_i && !bus.if_jump_i) begin
          w_state = IF_RD;
          w_len   = LEN_W;
          w_addr  = bus.if_addr_i;
          w_a     = bus.if_addr_i;
          w_cnt   = 3'd0;
          w_asm   = ZERO_WORD;
        end
      end
      IF_RD, MEM_RD: begin
        if (r_state == IF_RD && bus.if_jump_i) begin
          w_state = IDLE;
        end else begin
          w_cnt = w_idx;
          w_asm = (r_cnt == 3'd0) ? r_asm : w_cap;
          w_a   = (w_idx < r_len) ? w_step : r_a;
          if (r_cnt == r_len) begin
            w_state    = DONE;
            w_inst     = (r_state == IF_RD) ? w_cap : r_inst;
            w_rdata    = (r_state == MEM_RD) ? w_cap : r_rdata;
            w_inst_rdy = (r_state == IF_RD);
            w_done     = (r_state == MEM_RD);
          end
        end
      end
      MEM_WR: begin
        w_cnt = w_idx;
        if (w_idx < r_len) begin
          w_a    = w_step;
          w_dout = w_wbyte;
        end else begin
          w_wr    = 1'b0;
          w_done  = 1'b1;
          w_state = DONE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // FSM state register, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else if (rdy) r_state <= w_state;
  end
  // datapath and output registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= ZERO_WORD;
      r_asm      <= ZERO_WORD;
      r_a        <= '0;
      r_dout     <= 8'd0;
      r_wr       <= 1'b0;
      r_inst     <= ZERO_WORD;
      r_rdata    <= ZERO_WORD;
      r_inst_rdy <= 1'b0;
      r_done     <= 1'b0;
    end else if (rdy) begin
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_asm      <= w_asm;
      r_a        <= w_a;
      r_dout     <= w_dout;
      r_wr       <= w_wr;
      r_inst     <= w_inst;
      r_rdata    <= w_rdata;
      r_inst_rdy <= w_inst_rdy;
      r_done     <= w_done;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random accesses against a byte-addressed memory reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] wq [$];
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_byte(a + 32'(k));
    return w;
  endfunction
  function automatic int nlen(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? int'(l) : 4;
  endfunction
  task automatic put(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask
  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
  endtask
  // synchronous-read RAM, clock-enabled by rdy like the rest of the system
  always @(posedge clk) begin
    if (!rst && rdy) bus.ram_din_i <= ram.exists(bus.ram_a_o) ? ram[bus.ram_a_o] : pat(bus.ram_a_o);
    if (bus.ram_wr_o === 1'b1) ram[bus.ram_a_o] = bus.ram_dout_o;
  end
  always @(negedge clk) if (bus.ram_wr_o === 1'b1) wq.push_back({bus.ram_a_o, bus.ram_dout_o});
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask
  // kind 0 = fetch, 1 = load, 2 = store; optional rdy stall of s_n cycles starting s_at negedges in
  task automatic op(input int kind, input logic [2:0] len, input logic [31:0] addr,
                    input logic [31:0] wdata, input int s_at, input int s_n,
                    output int lat, output logic [31:0] data);
    int t0;
    @(negedge clk);
    t0 = cyc;
    wq.delete();
    if (kind == 0) begin
      bus.if_req_i = 1'b1;
      bus.if_addr_i = addr;
    end else begin
      bus.mem_req_i = 1'b1;
      bus.mem_we_i = (kind == 2);
      bus.mem_len_i = len;
      bus.mem_addr_i = addr;
      bus.mem_wdata_i = wdata;
    end
    lat = -1;
    data = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == s_at) rdy = 1'b0;
      if (i == s_at + s_n) rdy = 1'b1;
      if ((kind == 0) ? bus.inst_ready_o : bus.mem_done_o) begin
        lat = cyc - t0;
        data = (kind == 0) ? bus.inst_o : bus.mem_rdata_o;
        if (kind == 0) check("pc4_with_inst", 64'(bus.pc_plus4_ready_o), 64'(1));
        break;
      end
    end
    bus.if_req_i = 1'b0;
    bus.mem_req_i = 1'b0;
    rdy = 1'b1;
  endtask
  task automatic watch(input int n, input int t0, output int ni, output int nd, output int ti,
                       output int td, output logic [31:0] iv, output logic [31:0] rv);
    ni = 0; nd = 0; ti = -1; td = -1; iv = '0; rv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.inst_ready_o) begin
        ni++;
        if (ti < 0) begin ti = cyc - t0; iv = bus.inst_o; end
        bus.if_req_i = 1'b0;
      end
      if (bus.mem_done_o) begin
        nd++;
        if (td < 0) begin td = cyc - t0; rv = bus.mem_rdata_o; end
        bus.mem_req_i = 1'b0;
      end
    end
  endtask
  initial begin
    int t0, lat, ni, nd, ti, td, kind, n, base, s_at, s_n;
    logic [31:0] iv, rv, d, addr, wdata;
    logic [2:0] len;
    logic [2:0] lens [6];
    lens = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd4};
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_jump_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    put(32'h1000, 8'h13); put(32'h1001, 8'h05); put(32'h1002, 8'h00); put(32'h1003, 8'h00);
    put(32'h2000, 8'h11); put(32'h2001, 8'h22); put(32'h2002, 8'h33); put(32'h2003, 8'h44);
    put(32'h5000, 8'h93); put(32'h5001, 8'h00); put(32'h5002, 8'h10); put(32'h5003, 8'h00);
    put(32'hFFFFFFFF, 8'hA5); put(32'h0, 8'h3C);
    repeat (3) @(negedge clk);
    check("rst_ram_a", 64'(bus.ram_a_o), 64'(0));
    check("rst_ram_wr", 64'(bus.ram_wr_o), 64'(0));
    check("rst_inst_rdy", 64'(bus.inst_ready_o), 64'(0));
    check("rst_done", 64'(bus.mem_done_o), 64'(0));
    check("rst_inst", 64'(bus.inst_o), 64'(0));
    check("rst_rdata", 64'(bus.mem_rdata_o), 64'(0));
    rst = 1'b0;
    op(0, 3'd4, 32'h1000, '0, 0, 0, lat, d);
    check("fetch_lat", 64'(lat), 64'(6));
    check("fetch_inst", 64'(d), 64'(32'h00000513));
    check("fetch_nowr", 64'(wq.size()), 64'(0));
    @(negedge clk);
    t0 = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 3'd4; bus.mem_addr_i = 32'h2000;
    watch(25, t0, ni, nd, ti, td, iv, rv);
    check("both_done_lat", 64'(td), 64'(6));
    check("both_inst_lat", 64'(ti), 64'(13));
    check("both_done_cnt", 64'(nd), 64'(1));
    check("both_inst_cnt", 64'(ni), 64'(1));
    check("both_rdata", 64'(rv), 64'(32'h44332211));
    check("both_inst", 64'(iv), 64'(32'h00000513));
    op(2, 3'd2, 32'h3001, 32'hAABBCCDD, 0, 0, lat, d);
    ref_store(32'h3001, 2, 32'hAABBCCDD);
    check("st_lat", 64'(lat), 64'(3));
    check("st_nwr", 64'(wq.size()), 64'(2));
    check("st_wr0", 64'(wq[0]), 64'({32'h3001, 8'hDD}));
    check("st_wr1", 64'(wq[1]), 64'({32'h3002, 8'hCC}));
    op(1, 3'd4, 32'h3000, '0, 0, 0, lat, d);
    check("st_readback", 64'(d), 64'(ref_word(32'h3000, 4)));
    @(negedge clk);
    t0 = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    repeat (2) @(negedge clk);
    bus.if_jump_i = 1'b1; bus.if_addr_i = 32'h5000;
    @(negedge clk);
    bus.if_jump_i = 1'b0;
    watch(20, t0, ni, nd, ti, td, iv, rv);
    check("jmp_inst_cnt", 64'(ni), 64'(1));
    check("jmp_inst_lat", 64'(ti), 64'(9));
    check("jmp_inst", 64'(iv), 64'(32'h00100093));
    @(negedge clk);
    t0 = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    repeat (5) @(negedge clk);
    bus.if_jump_i = 1'b1;
    @(negedge clk);
    bus.if_jump_i = 1'b0; bus.if_req_i = 1'b0;
    check("jfin_now", 64'(bus.inst_ready_o), 64'(0));
    watch(8, t0, ni, nd, ti, td, iv, rv);
    check("jfin_cnt", 64'(ni), 64'(0));
    @(negedge clk);
    t0 = cyc;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h5000; bus.if_jump_i = 1'b1;
    @(negedge clk);
    bus.if_jump_i = 1'b0;
    watch(20, t0, ni, nd, ti, td, iv, rv);
    check("jacc_lat", 64'(ti), 64'(7));
    check("jacc_cnt", 64'(ni), 64'(1));
    check("jacc_inst", 64'(iv), 64'(32'h00100093));
    op(1, 3'd4, 32'h2000, '0, 2, 3, lat, d);
    check("stall_lat", 64'(lat), 64'(9));
    check("stall_data", 64'(d), 64'(32'h44332211));
    check("stall_nowr", 64'(wq.size()), 64'(0));
    op(1, 3'd1, 32'hFFFFFFFF, '0, 0, 0, lat, d);
    check("b_top_lat", 64'(lat), 64'(3));
    check("b_top_data", 64'(d), 64'(32'h000000A5));
    op(1, 3'd2, 32'hFFFFFFFF, '0, 0, 0, lat, d);
    check("h_wrap_lat", 64'(lat), 64'(4));
    check("h_wrap_data", 64'(d), 64'(32'h00003CA5));
    @(negedge clk);
    t0 = cyc;
    wq.delete();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 3'd4;
    bus.mem_addr_i = 32'h6000; bus.mem_wdata_i = 32'h11223344;
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.mem_req_i = 1'b0;
    @(negedge clk);
    check("rstmid_wr", 64'(bus.ram_wr_o), 64'(0));
    check("rstmid_a", 64'(bus.ram_a_o), 64'(0));
    rst = 1'b0;
    watch(6, t0, ni, nd, ti, td, iv, rv);
    check("rstmid_nodone", 64'(nd), 64'(0));
    check("rstmid_nwr", 64'(wq.size()), 64'(2));
    ref_store(32'h6000, 2, 32'h11223344);
    op(1, 3'd4, 32'h6000, '0, 0, 0, lat, d);
    check("rstmid_lat", 64'(lat), 64'(6));
    check("rstmid_data", 64'(d), 64'(ref_word(32'h6000, 4)));
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 2);
      len = lens[$urandom_range(0, 5)];
      n = (kind == 0) ? 4 : nlen(len);
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                          : 32'h4000 + 32'($urandom_range(0, 31));
      wdata = $urandom;
      base = (kind == 2) ? n + 1 : n + 2;
      s_at = 0;
      s_n = 0;
      if ($urandom_range(0, 2) == 0) begin
        s_at = $urandom_range(1, base - 1);
        s_n = $urandom_range(1, 4);
      end
      op(kind, len, addr, wdata, s_at, s_n, lat, d);
      check("rnd_lat", 64'(lat), 64'(base + s_n));
      if (kind == 2) begin
        check("rnd_st_nwr", 64'(wq.size()), 64'(n));
        for (int k = 0; k < n; k++)
          check("rnd_st_byte", 64'(wq[k]), 64'({addr + 32'(k), wdata[8*k +: 8]}));
        ref_store(addr, n, wdata);
      end else begin
        check("rnd_rd_data", 64'(d), 64'(ref_word(addr, n)));
        check("rnd_rd_nowr", 64'(wq.size()), 64'(0));
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
